// File: rtl/kf_pkg.sv
// Shared Kitten Fabric tile constants and types: spike flits and the
// multicast fan-out routing table / destination list formats.
package kf_pkg;

    localparam int KF_N_NEURONS         = 256;
    localparam int KF_NEURON_ID_BITS    = 8;
    localparam int KF_COORD_BITS        = 4;
    localparam int KF_FANOUT_DEST_DEPTH = 1024;
    localparam int KF_FANOUT_MAX        = 16;
    localparam int KF_FANOUT_FIFO_DEPTH = 8;
    localparam int KF_DEST_IDX_BITS     = $clog2(KF_FANOUT_DEST_DEPTH);
    localparam int KF_FANOUT_CNT_BITS   = $clog2(KF_FANOUT_MAX + 1);

    typedef struct packed {
        logic                          enable;
        logic [KF_DEST_IDX_BITS-1:0]   first_idx;
        logic [KF_FANOUT_CNT_BITS-1:0] count;
    } fanout_route_t;

    typedef struct packed {
        logic [KF_COORD_BITS-1:0] x;
        logic [KF_COORD_BITS-1:0] y;
    } fanout_dest_t;

    typedef struct packed {
        logic [7:0]                   dest_x;
        logic [7:0]                   dest_y;
        logic [KF_NEURON_ID_BITS-1:0] neuron_id;
        logic [7:0]                   payload;
    } spike_flit_t;

    typedef enum logic [1:0] {IDLE, TBL, DST, EMIT} fanout_state_t;

endpackage

// File: rtl/kf_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty/occupancy; DEPTH must be a
// power of two so the pointers wrap naturally.
module kf_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kf_spike_fanout_unit.sv
// Expands each core spike into 0..MAX_FANOUT router flits using a per-neuron
// routing table that points into a shared destination-list RAM.
module kf_spike_fanout_unit
    import kf_pkg::*;
#(
    parameter int N_NEURONS  = KF_N_NEURONS,
    parameter int MAX_FANOUT = KF_FANOUT_MAX,
    parameter int FIFO_DEPTH = KF_FANOUT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spike_in_valid,
    output logic                         spike_in_ready,
    input  logic [KF_NEURON_ID_BITS-1:0] spike_in_post_id,
    input  logic [7:0]                   spike_in_payload,
    output logic                         flit_out_valid,
    input  logic                         flit_out_ready,
    output spike_flit_t                  flit_out,
    input  logic                         cfg_we,
    input  logic                         cfg_sel,
    input  logic [15:0]                  cfg_addr,
    input  logic [31:0]                  cfg_wdata,
    output logic [31:0]                  flits_sent,
    output logic [15:0]                  spikes_dropped,
    output logic                         busy,
    output fanout_state_t                dbg_state
);

    // Handshakes: a transfer happens on a clk edge where valid && ready; once
    // flit_out_valid rises, it and flit_out hold until that edge.
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CB  = KF_FANOUT_CNT_BITS;
    localparam int IB  = KF_DEST_IDX_BITS;
    localparam logic [CB-1:0] CNT_ONE   = 1;
    localparam logic [CB-1:0] CNT_CLAMP = MAX_FANOUT;
    localparam logic [IB-1:0] IDX_ONE   = 1;

    fanout_state_t                  state;
    logic                           ready_en;
    logic                           fifo_full, fifo_empty, fifo_pop;
    logic [FAW:0]                   fifo_count;
    logic [15:0]                    fifo_rdata;
    logic [KF_NEURON_ID_BITS-1:0]   head_id, post_id_q;
    logic [7:0]                     head_pl, payload_q;
    logic [IB+CB-1:0]               tbl_ram [N_NEURONS];
    logic [IB+CB-1:0]               tbl_q;
    logic [N_NEURONS-1:0]           route_en;
    logic                           en_q;
    fanout_route_t                  route;
    fanout_dest_t                   dst_ram [KF_FANOUT_DEST_DEPTH];
    fanout_dest_t                   dst_q;
    logic                           tbl_we, dst_we, dst_re, route_ok, last_flit;
    logic [CB-1:0]                  wcnt, remaining;
    logic [IB-1:0]                  idx, dst_raddr;
    logic                           unused_bits;

    assign spike_in_ready = ready_en && !fifo_full;
    assign fifo_pop       = (state == IDLE) && !fifo_empty;
    assign head_id        = fifo_rdata[15:8];
    assign head_pl        = fifo_rdata[7:0];
    assign busy           = !fifo_empty || (state != IDLE);
    assign dbg_state      = state;
    assign unused_bits    = ^{cfg_wdata[30:26], cfg_wdata[15:8], fifo_count};

    kf_sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (spike_in_valid && spike_in_ready),
        .wdata ({spike_in_post_id, spike_in_payload}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tbl_we = cfg_we && !cfg_sel && (cfg_addr < 16'(N_NEURONS));
    assign dst_we = cfg_we && cfg_sel && (cfg_addr < 16'(KF_FANOUT_DEST_DEPTH));
    assign wcnt   = (cfg_wdata[CB-1:0] > CNT_CLAMP) ? CNT_CLAMP : cfg_wdata[CB-1:0];

    // RAM reads are read-first: the registered read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (tbl_we)   tbl_ram[cfg_addr[KF_NEURON_ID_BITS-1:0]] <= {cfg_wdata[16+IB-1:16], wcnt};
        if (fifo_pop) tbl_q <= tbl_ram[head_id];
        if (dst_we)   dst_ram[cfg_addr[IB-1:0]] <= fanout_dest_t'(cfg_wdata[7:0]);
        if (dst_re)   dst_q <= dst_ram[dst_raddr];
    end

    assign route     = '{enable: en_q, first_idx: tbl_q[IB+CB-1:CB], count: tbl_q[CB-1:0]};
    assign route_ok  = route.enable && (route.count != '0);
    assign last_flit = (remaining == CNT_ONE);
    assign dst_re    = ((state == TBL) && route_ok) ||
                       ((state == EMIT) && flit_out_ready && !last_flit);
    assign dst_raddr = (state == TBL) ? route.first_idx : idx + IDX_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ready_en       <= 1'b0;
            route_en       <= '0;
            en_q           <= 1'b0;
            post_id_q      <= '0;
            payload_q      <= '0;
            remaining      <= '0;
            idx            <= '0;
            flit_out_valid <= 1'b0;
            flit_out       <= '0;
            flits_sent     <= '0;
            spikes_dropped <= '0;
        end else begin
            ready_en <= 1'b1;
            if (tbl_we)   route_en[cfg_addr[KF_NEURON_ID_BITS-1:0]] <= cfg_wdata[31];
            if (fifo_pop) en_q <= route_en[head_id];
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        post_id_q <= head_id;
                        payload_q <= head_pl;
                        state     <= TBL;
                    end
                end
                TBL: begin
                    if (!route_ok) begin
                        if (spikes_dropped != 16'hFFFF) spikes_dropped <= spikes_dropped + 16'd1;
                        state <= IDLE;
                    end else begin
                        remaining <= route.count;
                        idx       <= route.first_idx;
                        state     <= DST;
                    end
                end
                DST: begin
                    flit_out <= '{dest_x: 8'(dst_q.x), dest_y: 8'(dst_q.y),
                                  neuron_id: post_id_q, payload: payload_q};
                    flit_out_valid <= 1'b1;
                    state          <= EMIT;
                end
                EMIT: begin
                    if (flit_out_ready) begin
                        flits_sent     <= flits_sent + 32'd1;
                        remaining      <= remaining - CNT_ONE;
                        flit_out_valid <= 1'b0;
                        if (last_flit) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + IDX_ONE;
                            state <= DST;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kf_spike_fanout_unit.sv
// Bench for kf_spike_fanout_unit: directed scenarios plus random traffic,
// checked against a table-level model of the routing rules.
module tb_kf_spike_fanout_unit;
    import kf_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spike_in_valid = 1'b0;
    logic          spike_in_ready;
    logic [7:0]    spike_in_post_id = '0;
    logic [7:0]    spike_in_payload = '0;
    logic          flit_out_valid;
    logic          flit_out_ready = 1'b0;
    spike_flit_t   flit_out;
    logic          cfg_we = 1'b0;
    logic          cfg_sel = 1'b0;
    logic [15:0]   cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   flits_sent;
    logic [15:0]   spikes_dropped;
    logic          busy;
    fanout_state_t dbg_state;

    kf_spike_fanout_unit dut (
        .clk(clk), .rst_n(rst_n),
        .spike_in_valid(spike_in_valid), .spike_in_ready(spike_in_ready),
        .spike_in_post_id(spike_in_post_id), .spike_in_payload(spike_in_payload),
        .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready), .flit_out(flit_out),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .flits_sent(flits_sent), .spikes_dropped(spikes_dropped), .busy(busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    int          acc_cyc[$];
    bit          m_en[256];
    int          m_first[256];
    int          m_cnt[256];
    logic [3:0]  m_x[1024];
    logic [3:0]  m_y[1024];
    int          model_sent = 0;
    int          model_dropped = 0;
    bit          chk_en = 0;
    int          rdy_mode = 0;
    int          push_cyc = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_flit = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Model: a spike becomes count flits over dest[first..first+count-1] mod 1024.
    task automatic model_spike(input int id, input int pl);
        int i;
        if (!m_en[id] || m_cnt[id] == 0) begin
            if (model_dropped < 65535) model_dropped++;
        end else begin
            for (int k = 0; k < m_cnt[id]; k++) begin
                i = (m_first[id] + k) % 1024;
                exp_q.push_back({4'h0, m_x[i], 4'h0, m_y[i], 8'(id), 8'(pl)});
            end
        end
    endtask

    function automatic logic [31:0] route_word(input bit en, input int first, input int cnt);
        return {en, 5'b0, 10'(first), 11'b0, 5'(cnt)};
    endfunction

    task automatic cfg_write(input bit sel, input int addr, input logic [31:0] data);
        cfg_sel = sel; cfg_addr = 16'(addr); cfg_wdata = data; cfg_we = 1'b1;
        if (!sel && addr < 256) begin
            m_en[addr]    = data[31];
            m_first[addr] = int'(data[25:16]);
            m_cnt[addr]   = (int'(data[4:0]) > 16) ? 16 : int'(data[4:0]);
        end else if (sel && addr < 1024) begin
            m_x[addr] = data[7:4];
            m_y[addr] = data[3:0];
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send_spike(input int id, input int pl, input int budget, output bit ok);
        spike_in_valid = 1'b1; spike_in_post_id = 8'(id); spike_in_payload = 8'(pl); ok = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (spike_in_ready) begin
                model_spike(id, pl);
                push_cyc = cyc + 1;
                @(posedge clk); #1;
                ok = 1;
                break;
            end
        end
        if (!ok) begin @(posedge clk); #1; end
        spike_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int t = 0; t < budget; t++) begin
            if (!busy && exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("busy_idle", 32'(busy), 0);
        check("exp_q_drained", exp_q.size(), 0);
        check("spikes_dropped", 32'(spikes_dropped), 32'(model_dropped));
    endtask

    task automatic wait_sent(input int target);
        for (int t = 0; t < 50 && model_sent < target; t++) begin @(posedge clk); #1; end
        check("sent_reached", 32'(model_sent >= target), 1);
    endtask

    // Flit-side ready generator.
    initial begin
        forever begin
            @(posedge clk); #2;
            case (rdy_mode)
                0:       flit_out_ready = 1'b1;
                1:       flit_out_ready = 1'($urandom_range(0, 1));
                default: flit_out_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle compare: counter, hold stability, and accepted flit contents.
    always @(negedge clk) begin
        if (!chk_en) begin
            prev_hold = 0;
        end else begin
            check("flits_sent", flits_sent, 32'(model_sent));
            if (prev_hold) begin
                check("hold_valid", 32'(flit_out_valid), 1);
                check("hold_flit", flit_out, prev_flit);
            end
            if (flit_out_valid && flit_out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_flit: got 0x%08h, expected none", flit_out);
                end else begin
                    check("flit_data", flit_out, exp_q.pop_front());
                end
                model_sent++;
                acc_cyc.push_back(cyc);
            end
            prev_hold = flit_out_valid && !flit_out_ready;
            prev_flit = flit_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int accepted;
        int gap;

        // Reset values.
        repeat (3) @(posedge clk);
        #3;
        check("rst_valid", 32'(flit_out_valid), 0);
        check("rst_flit", flit_out, 0);
        check("rst_sent", flits_sent, 0);
        check("rst_dropped", 32'(spikes_dropped), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(spike_in_ready), 1);
        chk_en = 1;

        // Unrouted spike is dropped quickly.
        send_spike(5, 8'h11, 20, ok);
        check("accept_drop", 32'(ok), 1);
        for (int i = 0; i < 3 && busy; i++) begin @(posedge clk); #1; end
        check("drop_busy3", 32'(busy), 0);
        check("drop_count", 32'(spikes_dropped), 1);
        wait_idle(20);

        // Three-way fanout with ready held high.
        cfg_write(1, 10, 32'h12);
        cfg_write(1, 11, 32'h30);
        cfg_write(1, 12, 32'h03);
        cfg_write(0, 5, route_word(1, 10, 3));
        acc_cyc.delete();
        send_spike(5, 8'hA7, 20, ok);
        check("pin_n", exp_q.size(), 3);
        check("pin_f0", exp_q[0], 32'h010205A7);
        check("pin_f1", exp_q[1], 32'h030005A7);
        check("pin_f2", exp_q[2], 32'h000305A7);
        wait_idle(100);
        check("lat_first", 32'(acc_cyc[0] - push_cyc + 1), 4);
        check("gap_1_2", 32'(acc_cyc[1] - acc_cyc[0]), 2);
        check("gap_2_3", 32'(acc_cyc[2] - acc_cyc[1]), 2);
        check("sent_after_3", flits_sent, 3);

        // Back-pressure on the second flit.
        send_spike(5, 8'hA7, 20, ok);
        wait_sent(4);
        rdy_mode = 2;
        repeat (5) begin @(posedge clk); #1; end
        check("stall_valid", 32'(flit_out_valid), 1);
        check("stall_sent", flits_sent, 4);
        rdy_mode = 0;
        wait_idle(100);
        check("sent_after_stall", flits_sent, 6);

        // Destination index wraps at the end of the list.
        cfg_write(1, 1023, 32'h56);
        cfg_write(1, 0, 32'h78);
        cfg_write(0, 9, route_word(1, 1023, 2));
        send_spike(9, 8'hC3, 20, ok);
        check("pin_wrap0", exp_q[0], 32'h050609C3);
        check("pin_wrap1", exp_q[1], 32'h070809C3);
        wait_idle(100);
        check("sent_after_wrap", flits_sent, 8);

        // Out-of-range config writes must not alias onto real entries.
        cfg_write(0, 16'h0105, 32'h0);
        cfg_write(1, 16'h040A, 32'hFF);
        send_spike(5, 8'h55, 20, ok);
        check("pin_oor", exp_q[0], 32'h01020555);
        wait_idle(100);
        check("sent_after_oor", flits_sent, 11);

        // Burst against a stalled router: 8 in FIFO plus 1 in the FSM.
        rdy_mode = 2;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            send_spike(5, 16 + i, 10, ok);
            if (ok) accepted++;
            spike_in_valid = 1'b1;
        end
        spike_in_valid = 1'b0;
        check("burst_accepted", 32'(accepted), 9);
        check("burst_ready_low", 32'(spike_in_ready), 0);
        rdy_mode = 1;
        send_spike(5, 8'h19, 200, ok);
        check("burst_last_accept", 32'(ok), 1);
        wait_idle(2000);
        check("sent_after_burst", flits_sent, 41);

        // Random routes, destinations and traffic.
        for (int a = 0; a < 1024; a++) cfg_write(1, a, 32'($urandom_range(0, 255)));
        for (int n = 20; n < 36; n++)
            cfg_write(0, n, route_word($urandom_range(0, 3) != 0, $urandom_range(0, 1023),
                                       $urandom_range(0, 20)));
        for (int s = 0; s < 40; s++) begin
            send_spike($urandom_range(20, 35), $urandom_range(0, 255), 400, ok);
            check("rand_accept", 32'(ok), 1);
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
        end
        wait_idle(20000);

        // Reset in the middle of a fanout.
        cfg_write(1, 10, 32'h12);
        cfg_write(1, 11, 32'h30);
        cfg_write(1, 12, 32'h03);
        cfg_write(0, 5, route_word(1, 10, 3));
        rdy_mode = 0;
        send_spike(5, 8'hA7, 20, ok);
        wait_sent(model_sent + 1);
        rdy_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        chk_en = 0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(flit_out_valid), 0);
        check("mid_rst_flit", flit_out, 0);
        check("mid_rst_sent", flits_sent, 0);
        check("mid_rst_dropped", 32'(spikes_dropped), 0);
        check("mid_rst_busy", 32'(busy), 0);
        #3 rst_n = 1'b1;
        exp_q.delete();
        model_sent = 0;
        model_dropped = 0;
        foreach (m_en[i]) m_en[i] = 0;
        @(posedge clk); #1;
        chk_en = 1;
        rdy_mode = 0;
        check("post_rst_ready", 32'(spike_in_ready), 1);
        repeat (10) begin @(posedge clk); #1; end
        check("post_rst_no_flit", 32'(flit_out_valid), 0);
        send_spike(5, 8'hA7, 20, ok);
        wait_idle(50);
        check("post_rst_dropped", 32'(spikes_dropped), 1);
        check("post_rst_sent", flits_sent, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kf_spike_fanout_unit.md
Name: kf_spike_fanout_unit

Overview:
- Sits between the kf_snn_core spike output and the kf_noc_router local input port in each Kitten Fabric tile.
- Replaces the fixed scheme where "payload encodes the destination tile" with a configurable per-neuron multicast routing table.
- Each output spike is buffered and looked up. It is then expanded into 0..MAX_FANOUT spike flits, each addressed to a configured (x,y) tile.

Parameters:
- N_NEURONS, 256, neurons per tile; routing-table depth.
- DEST_DEPTH, 1024, entries in the shared destination-list RAM.
- MAX_FANOUT, 16, maximum destinations per neuron.
- FIFO_DEPTH, 8, input spike FIFO depth; power of 2, ≥2.
- COORD_BITS, 4, stored bits per mesh coordinate; zero-extended to 8 in the flit.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset (see Behaviour).
- spike_in_valid, in, 1, core spike valid.
- spike_in_ready, out, 1, FIFO not full.
- spike_in_post_id, in, KF_NEURON_ID_BITS, firing neuron.
- spike_in_payload, in, 8, spike payload.
- flit_out_valid, out, 1, flit to router local port.
- flit_out_ready, in, 1, router accepts.
- flit_out, out, spike_flit_t, {dest_x, dest_y, neuron_id, payload}.
- cfg_we, in, 1, config write strobe.
- cfg_sel, in, 1, 0 = routing table, 1 = destination list.
- cfg_addr, in, 16, entry index.
- cfg_wdata, in, 32, entry data (formats below).
- flits_sent, out, 32, wrapping count of accepted flits.
- spikes_dropped, out, 16, saturating count of spikes with no route.
- busy, out, 1, FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock.
  - On reset: FIFO empties; FSM goes to IDLE; flit_out_valid=0; flit_out=0; flits_sent=0; spikes_dropped=0; busy=0.
  - All N_NEURONS route-enable flops clear to 0. RAM contents are not reset.
  - spike_in_ready=1 one cycle after reset deasserts.
  - Reset asserted mid-fanout abandons the remaining flits, with no partial output afterwards.
- Input FIFO:
  - Push when spike_in_valid && spike_in_ready.
  - spike_in_ready = !full.
  - Simultaneous push and pop while full is not allowed, because ready is already low.
- Routing table entry (cfg_sel=0):
  - cfg_wdata[31] = enable; stored in a separate flop.
  - [25:16] = first_idx, log2(DEST_DEPTH) bits.
  - [4:0] = count, 0..MAX_FANOUT; values above MAX_FANOUT are clamped on write.
- Destination list entry (cfg_sel=1):
  - [7:4] = x, [3:0] = y (COORD_BITS each).
- Config writes with out-of-range cfg_addr are ignored.
- Both RAMs are single-cycle synchronous read, read-first. A write and a read to the same address in the same cycle returns the old data.
- FSM:
  - IDLE: if FIFO not empty, pop, latch post_id/payload, issue table read → TBL.
  - TBL: if !enable[post_id] or count==0, spikes_dropped++ (saturate at 0xFFFF) → IDLE. Otherwise remaining=count, idx=first_idx, issue dest read → DST.
  - DST: register the flit, with dest_x/dest_y zero-extended to 8 bits, neuron_id=post_id, payload=latched payload. Assert flit_out_valid → EMIT.
  - EMIT: flit_out_valid and flit_out stay stable until flit_out_ready.
    - On accept: flits_sent++, remaining--.
    - If remaining==0 → IDLE, with valid dropping in the same edge.
    - Else idx = (idx+1) mod DEST_DEPTH (wraps at DEST_DEPTH-1), issue dest read → DST.
- Latency and throughput:
  - Spike in to first flit valid is 4 cycles minimum (push, IDLE pop, TBL, DST).
  - Steady fan-out is 1 flit per 2 cycles.
  - Spikes are processed strictly in FIFO order; fanout order is ascending idx.
- Config writes during fanout take effect on the next RAM read. A table entry already latched in TBL is not re-read.
- A destination equal to the local tile is emitted normally; the router loops it back.

Decomposition:
- Add to kf_pkg:
  - KF_FANOUT_DEST_DEPTH, KF_FANOUT_MAX and KF_FANOUT_FIFO_DEPTH constants.
  - fanout_route_t {enable, first_idx, count} and fanout_dest_t {x, y} typedefs.
  - fanout_state_t enum {IDLE, TBL, DST, EMIT}.
- One sub-module, kf_sync_fifo (parametrised width/depth, full/empty/count), is reused by later router buffering.
- The RAMs are inferred inline.

Test Plan:
- Reset only, then a spike on neuron 5 → no flit, spikes_dropped=1, busy returns 0 within 3 cycles.
- Neuron 5 route {en=1, first=10, count=3}, dests[10..12]=(1,2),(3,0),(0,3), ready held 1:
  - Spike(5, payload 0xA7) → flits dest (1,2),(3,0),(0,3), each neuron_id=5, payload=0xA7.
  - First valid at cycle 4; then one flit every 2 cycles; flits_sent=3.
- Same setup, flit_out_ready low for 5 cycles on the second flit → flit held stable, no duplicate or loss, flits_sent=3 at the end.
- Route {first=DEST_DEPTH-1, count=2} → flits use dest[1023] then dest[0].
- Burst of 10 back-to-back spikes with ready=0 → spike_in_ready falls after 8 accepted (plus 1 in the FSM). Releasing ready → all fanouts emitted in order.
- Assert rst_n mid-fanout (after 1 of 3 flits) → valid drops immediately, counters 0, no further flits. Enables cleared, so a re-sent spike is dropped.
